// File: rtl/cdr_pkg.sv
// Shared types and helpers for the CDR phase controller.
package cdr_pkg;

   // Loop controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Width of the signed vote accumulator: holds +/-WIN_LEN without overflow
   function automatic int unsigned vote_width(input int unsigned win_len);
      return $clog2(win_len) + 2;
   endfunction

   // Width of the blanking counter (counts 0..holdoff-1)
   function automatic int unsigned hold_width(input int unsigned holdoff);
      return (holdoff > 1) ? $clog2(holdoff) : 1;
   endfunction

   localparam int unsigned VOTE_W = vote_width(16);
   localparam int unsigned HOLD_W = hold_width(4);

   // Decode one phase-detector sample into +1 / -1 / 0
   function automatic logic signed [1:0] vote_decode(input logic up, input logic down);
      case ({up, down})
         2'b10:   return 2'sb01;
         2'b01:   return 2'sb11;
         default: return 2'sb00;
      endcase
   endfunction

endpackage

// File: rtl/cdr_vote_integrator.sv
// Window counter and signed vote accumulator. window_end flags the last
// cycle of a window; net is the window total including the current vote.
module cdr_vote_integrator
   import cdr_pkg::*;
#(
   parameter int unsigned WIN_LEN = 16,
   parameter int unsigned VW      = vote_width(WIN_LEN)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 acc_en,
   input  logic signed [1:0]    vote,
   output logic                 window_end,
   output logic signed [VW-1:0] net
);

   localparam int unsigned CNT_W = $clog2(WIN_LEN);

   logic [CNT_W-1:0]     cnt;
   logic signed [VW-1:0] acc;
   logic signed [VW-1:0] vote_ext;

   assign vote_ext   = {{(VW-2){vote[1]}}, vote};
   assign net        = acc + vote_ext;
   assign window_end = acc_en && !clr && (cnt == CNT_W'(WIN_LEN - 1));

   // Accumulate votes; every window boundary restarts the window
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
         acc <= '0;
      end else if (acc_en) begin
         if (window_end) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            cnt <= cnt + 1'b1;
            acc <= net;
         end
      end
   end

endmodule

// File: rtl/cdr_phase_controller.sv
// Bang-bang CDR loop controller: integrates phase-detector votes per window,
// steps the phase-select pointer, blanks the detector after steps and
// reports lock.
module cdr_phase_controller
   import cdr_pkg::*;
#(
   parameter int unsigned NPHASE       = 8,
   parameter int unsigned PSEL_W       = 3,
   parameter int unsigned WIN_LEN      = 16,
   parameter int unsigned THRESH       = 4,
   parameter int unsigned HOLDOFF      = 4,
   parameter int unsigned LOCK_WINDOWS = 4,
   parameter int unsigned INIT_PHASE   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              up,
   input  logic              down,
   input  logic              ovr_en,
   input  logic [PSEL_W-1:0] ovr_sel,
   output logic [PSEL_W-1:0] phase_sel,
   output logic              step_up,
   output logic              step_dn,
   output logic              pd_rst,
   output logic              locked
);

   localparam int unsigned VW = vote_width(WIN_LEN);
   localparam int unsigned HW = hold_width(HOLDOFF);
   localparam int unsigned QW = $clog2(LOCK_WINDOWS + 1);
   localparam logic signed [VW-1:0] THR_POS = VW'(THRESH);
   localparam logic signed [VW-1:0] THR_NEG = -THR_POS;

   state_t               state, state_nx;
   logic [HW-1:0]        hold_cnt, hold_nx;
   logic [PSEL_W-1:0]    phase_nx;
   logic                 up_nx, dn_nx, locked_nx;
   logic [QW-1:0]        quiet, quiet_nx;
   logic                 window_end;
   logic signed [VW-1:0] net;
   logic                 int_clr;

   assign int_clr = !en || ovr_en || (state != COUNT);
   assign pd_rst  = (state != COUNT);

   cdr_vote_integrator #(
      .WIN_LEN (WIN_LEN),
      .VW      (VW)
   ) u_integ (
      .clk        (clk),
      .rst        (rst),
      .clr        (int_clr),
      .acc_en     (state == COUNT),
      .vote       (vote_decode(up, down)),
      .window_end (window_end),
      .net        (net)
   );

   // State, phase pointer, step pulses and lock registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         phase_sel <= PSEL_W'(INIT_PHASE);
         step_up   <= 1'b0;
         step_dn   <= 1'b0;
         quiet     <= '0;
         locked    <= 1'b0;
      end else begin
         state     <= state_nx;
         hold_cnt  <= hold_nx;
         phase_sel <= phase_nx;
         step_up   <= up_nx;
         step_dn   <= dn_nx;
         quiet     <= quiet_nx;
         locked    <= locked_nx;
      end
   end

   // Next-state, phase step decision and quiet-window tracking
   always_comb begin
      state_nx = state;
      hold_nx  = hold_cnt;
      phase_nx = phase_sel;
      up_nx    = 1'b0;
      dn_nx    = 1'b0;
      quiet_nx = quiet;
      if (ovr_en) begin
         phase_nx = ovr_sel;
         quiet_nx = '0;
         hold_nx  = '0;
         state_nx = en ? HOLD : IDLE;
      end else if (!en) begin
         state_nx = IDLE;
         quiet_nx = '0;
      end else begin
         case (state)
            IDLE: state_nx = COUNT;
            COUNT: begin
               if (window_end) begin
                  if (net >= THR_POS) begin
                     phase_nx = (phase_sel == PSEL_W'(NPHASE - 1)) ? '0 : phase_sel + 1'b1;
                     up_nx    = 1'b1;
                     quiet_nx = '0;
                     hold_nx  = '0;
                     state_nx = HOLD;
                  end else if (net <= THR_NEG) begin
                     phase_nx = (phase_sel == '0) ? PSEL_W'(NPHASE - 1) : phase_sel - 1'b1;
                     dn_nx    = 1'b1;
                     quiet_nx = '0;
                     hold_nx  = '0;
                     state_nx = HOLD;
                  end else if (quiet != QW'(LOCK_WINDOWS)) begin
                     quiet_nx = quiet + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (hold_cnt == HW'(HOLDOFF - 1)) state_nx = COUNT;
               else                              hold_nx  = hold_cnt + 1'b1;
            end
            default: state_nx = IDLE;
         endcase
      end
      locked_nx = (quiet_nx == QW'(LOCK_WINDOWS));
   end

endmodule
